// File: rtl/uart_tx_fifo_pkg.sv
// uart_pkg: transmitter FSM state encoding, oversampling ratio and a small sizing helper
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-write strobe/data from the host plus FIFO status and serial line back
interface uart_tx_fifo_if;
  logic       I_WR_UART;
  logic [7:0] I_DATA_UART;
  logic       O_TX_FULL;
  logic       O_TX_EMPTY;
  logic       O_TX_BUSY;
  logic       O_TX;
  modport master (output I_WR_UART, I_DATA_UART, input O_TX_FULL, O_TX_EMPTY, O_TX_BUSY, O_TX);
  modport slave (input I_WR_UART, I_DATA_UART, output O_TX_FULL, O_TX_EMPTY, O_TX_BUSY, O_TX);
endinterface

// File: rtl/uart_tx_fifo_fifo_sync.sv
// fifo_sync: single-clock FIFO, depth 2^ADDR_W; pushes while full and pops while empty are ignored
module fifo_sync #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = ADDR_W + 1;
  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;
  assign o_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {ADDR_W{1'b0}}};
  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  // storage write; slots are only read after being pushed, so no reset is needed
  always_ff @(posedge CLK)
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
  // wrap-bit pointers: equal means empty, differing only in the wrap bit means full
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter; define UART_TX_PARITY_EN to append an even parity bit
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int FIFO_W   = 4,
  parameter int BAUD_DIV = 326
) (
  input logic           CLK,
  input logic           RESET,
  uart_tx_fifo_if.slave bus
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(max_int(OVERSAMPLE, SB_TICK) + 1);
  localparam int BW = $clog2(DBIT + 1);
  tx_state_t       r_state;
  logic [CW-1:0]   r_baud_cnt;
  logic [TW-1:0]   r_tick_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [DBIT-1:0] r_shift;
  logic            r_tx;
  logic            r_busy;
`ifdef UART_TX_PARITY_EN
  logic            r_parity;
`endif
  logic            w_tick;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [7:0]      w_fifo_data;
  logic [DBIT-1:0] w_shift_nx;
  fifo_sync #(.WIDTH(8), .ADDR_W(FIFO_W)) u_fifo (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_push (bus.I_WR_UART),
    .i_pop  (w_pop),
    .i_data (bus.I_DATA_UART),
    .o_data (w_fifo_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign w_tick         = r_baud_cnt == CW'(BAUD_DIV - 1);
  assign w_pop          = (r_state == ST_IDLE) && !w_empty;
  assign w_shift_nx     = r_shift >> 1;
  assign bus.O_TX_FULL  = w_full;
  assign bus.O_TX_EMPTY = w_empty;
  assign bus.O_TX_BUSY  = r_busy;
  assign bus.O_TX       = r_tx;
  // oversampling tick generator, parked at zero while idle so each frame starts phase-aligned
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_baud_cnt <= '0;
    else r_baud_cnt <= (r_state == ST_IDLE || w_tick) ? '0 : r_baud_cnt + CW'(1);
  // transmit FSM; line and busy are registered together with the state so the line never glitches
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop) begin
          r_state    <= ST_START;
          r_shift    <= w_fifo_data[DBIT-1:0];
          r_tick_cnt <= '0;
          r_tx       <= 1'b0;
          r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
          r_parity   <= ^w_fifo_data[DBIT-1:0];
`endif
        end
        ST_START: if (w_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            r_state    <= ST_DATA;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= r_shift[0];
          end else r_tick_cnt <= r_tick_cnt + TW'(1);
        end
        ST_DATA: if (w_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            r_tick_cnt <= '0;
            r_shift    <= w_shift_nx;
            r_bit_cnt  <= r_bit_cnt + BW'(1);
            if (r_bit_cnt == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else r_tx <= w_shift_nx[0];
          end else r_tick_cnt <= r_tick_cnt + TW'(1);
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (w_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            r_state    <= ST_STOP;
            r_tick_cnt <= '0;
            r_tx       <= 1'b1;
          end else r_tick_cnt <= r_tick_cnt + TW'(1);
        end
`endif
        ST_STOP: if (w_tick) begin
          if (r_tick_cnt == TW'(SB_TICK - 1)) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_busy     <= 1'b0;
          end else r_tick_cnt <= r_tick_cnt + TW'(1);
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, timing, FIFO full/drop behaviour and async reset at BAUD_DIV=2
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * 32;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  uart_tx_fifo_if u_if ();
  uart_tx_fifo #(.BAUD_DIV(2)) dut (.CLK(CLK), .RESET(RESET), .bus(u_if));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic wr(input logic [7:0] d);
    u_if.I_WR_UART = 1'b1;
    u_if.I_DATA_UART = d;
    step(1);
    u_if.I_WR_UART = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (u_if.O_TX_BUSY && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_idle", 32'(u_if.O_TX_BUSY), 0);
  endtask
  task automatic frame_chk(input string tag, input logic [7:0] d);
    logic [10:0] f;
    f = {2'b11, d, 1'b0};
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    for (int o = 0; o < FL; o++) begin
      if (o % 32 == 0) begin
        chk({tag, "_head"}, 32'(u_if.O_TX), 32'(f[o / 32]));
        chk({tag, "_busy"}, 32'(u_if.O_TX_BUSY), 1);
      end
      if (o % 32 == 31) chk({tag, "_tail"}, 32'(u_if.O_TX), 32'(f[o / 32]));
      step(1);
    end
    chk({tag, "_end_busy"}, 32'(u_if.O_TX_BUSY), 0);
    chk({tag, "_end_tx"}, 32'(u_if.O_TX), 1);
  endtask
  task automatic rx(output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    while (u_if.O_TX && n < 400) begin
      step(1);
      n++;
    end
    chk("rx_start", 32'(u_if.O_TX), 0);
    step(16);
    for (int k = 0; k < 8; k++) begin
      step(32);
      b[k] = u_if.O_TX;
    end
`ifdef UART_TX_PARITY_EN
    step(32);
    chk("rx_parity", 32'(u_if.O_TX), 32'(^b));
`endif
    step(32);
    chk("rx_stop", 32'(u_if.O_TX), 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    logic [7:0] b;
    logic seen;
    u_if.I_WR_UART = 1'b0;
    u_if.I_DATA_UART = '0;
    step(2);
    chk("rst_tx", 32'(u_if.O_TX), 1);
    chk("rst_busy", 32'(u_if.O_TX_BUSY), 0);
    chk("rst_full", 32'(u_if.O_TX_FULL), 0);
    chk("rst_empty", 32'(u_if.O_TX_EMPTY), 1);
    RESET = 1'b0;
    step(1);
    wr(8'hA5);
    chk("a5_empty_pre", 32'(u_if.O_TX_EMPTY), 0);
    step(1);
    chk("a5_empty_post", 32'(u_if.O_TX_EMPTY), 1);
    frame_chk("a5", 8'hA5);
    wr(8'h07);
    step(1);
    frame_chk("x07", 8'h07);
    wr(8'h00);
    wr(8'hFF);
    for (int o = 0; o <= FL + 33; o++) begin
      if (o == 0) chk("b2b_start1", 32'(u_if.O_TX), 0);
      if (o == 287) chk("b2b_d7", 32'(u_if.O_TX), 0);
      if (o == (NB - 1) * 32) chk("b2b_stop", 32'(u_if.O_TX), 1);
      if (o == FL - 1) begin
        chk("b2b_stop_end", 32'(u_if.O_TX), 1);
        chk("b2b_stop_busy", 32'(u_if.O_TX_BUSY), 1);
      end
      if (o == FL) begin
        chk("b2b_gap_tx", 32'(u_if.O_TX), 1);
        chk("b2b_gap_busy", 32'(u_if.O_TX_BUSY), 0);
      end
      if (o == FL + 1) begin
        chk("b2b_start2", 32'(u_if.O_TX), 0);
        chk("b2b_start2_busy", 32'(u_if.O_TX_BUSY), 1);
      end
      if (o == FL + 32) chk("b2b_start2_end", 32'(u_if.O_TX), 0);
      if (o == FL + 33) chk("b2b_ff_d0", 32'(u_if.O_TX), 1);
      step(1);
    end
    wait_idle(400);
    for (int c = 0; c < 20; c++) begin
      u_if.I_WR_UART = 1'b1;
      u_if.I_DATA_UART = 8'(c);
      step(1);
      if (c == 15) chk("fill_16_notfull", 32'(u_if.O_TX_FULL), 0);
      if (c == 16) chk("fill_17_full", 32'(u_if.O_TX_FULL), 1);
      if (c == 19) chk("fill_20_full", 32'(u_if.O_TX_FULL), 1);
    end
    u_if.I_WR_UART = 1'b0;
    wait_idle(400);
    for (int k = 1; k <= 16; k++) begin
      rx(b);
      chk("fill_order", 32'(b), 32'(k));
    end
    seen = 1'b0;
    repeat (400) begin
      if (!u_if.O_TX) seen = 1'b1;
      step(1);
    end
    chk("fill_no_extra", 32'(seen), 0);
    chk("fill_empty", 32'(u_if.O_TX_EMPTY), 1);
    for (int k = 0; k < 17; k++) wr(8'h3F + 8'(k));
    chk("pp_full", 32'(u_if.O_TX_FULL), 1);
    wait_idle(400);
    chk("pp_full_at_idle", 32'(u_if.O_TX_FULL), 1);
    u_if.I_WR_UART = 1'b1;
    u_if.I_DATA_UART = 8'hEE;
    step(1);
    u_if.I_WR_UART = 1'b0;
    chk("pp_occ15_notfull", 32'(u_if.O_TX_FULL), 0);
    chk("pp_busy", 32'(u_if.O_TX_BUSY), 1);
    wr(8'h50);
    chk("pp_occ16_full", 32'(u_if.O_TX_FULL), 1);
    for (int k = 0; k < 16; k++) begin
      rx(b);
      chk("pp_order", 32'(b), 32'(8'h40 + 8'(k)));
    end
    rx(b);
    chk("pp_last", 32'(b), 32'h50);
    wait_idle(400);
    wr(8'h3C);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    step(48);
    chk("rst_pre_tx", 32'(u_if.O_TX), 0);
    chk("rst_pre_busy", 32'(u_if.O_TX_BUSY), 1);
    chk("rst_pre_empty", 32'(u_if.O_TX_EMPTY), 0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(u_if.O_TX), 1);
    chk("rst_mid_busy", 32'(u_if.O_TX_BUSY), 0);
    chk("rst_mid_empty", 32'(u_if.O_TX_EMPTY), 1);
    chk("rst_mid_full", 32'(u_if.O_TX_FULL), 0);
    step(1);
    #2 RESET = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      step(1);
      if (!u_if.O_TX || !u_if.O_TX_EMPTY || u_if.O_TX_BUSY) seen = 1'b1;
    end
    chk("rst_no_frames", 32'(seen), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, stop-bit length in oversampling ticks.
REQ-003 SHALL have parameter FIFO_W, default 4, FIFO address width, depth 2^FIFO_W.
REQ-004 SHALL have parameter BAUD_DIV, default 326, CLK cycles per oversampling tick (16x baud).
REQ-005 SHALL have port CLK  input  1  clock, rising edge.
REQ-006 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port I_WR_UART  input  1  write strobe, one byte per cycle high.
REQ-008 SHALL have port I_DATA_UART  input  8  byte to enqueue.
REQ-009 SHALL have port O_TX_FULL  output  1  FIFO full.
REQ-010 SHALL have port O_TX_EMPTY  output  1  FIFO empty.
REQ-011 SHALL have port O_TX_BUSY  output  1  frame in progress (FSM not IDLE).
REQ-012 SHALL have port O_TX  output  1  serial line, idle high.

Function
REQ-013 SHALL enqueue I_DATA_UART on each rising edge with I_WR_UART=1 and O_TX_FULL=0; writes while full are dropped, no overwrite, even if a pop occurs in the same cycle.
REQ-014 SHALL derive O_TX_FULL/O_TX_EMPTY from registered pointers, valid the cycle after the causing edge; simultaneous push and pop keeps occupancy unchanged.
REQ-015 SHALL hold baud counter at 0 in IDLE; otherwise count 0..BAUD_DIV-1 and wrap, one-cycle tick at BAUD_DIV-1.
REQ-016 SHALL implement FSM IDLE, START, DATA, STOP (plus PARITY per REQ-024).
REQ-017 IDLE: O_TX=1; if O_TX_EMPTY=0, pop head into shift register, go START on that edge.
REQ-018 START: O_TX=0 for 16 ticks, then DATA.
REQ-019 DATA: send DBIT bits LSB first, 16 ticks each, then STOP.
REQ-020 STOP: O_TX=1 for SB_TICK ticks, then IDLE; next pop no earlier than the following cycle.
REQ-021 Latency: byte written at edge t into empty FIFO with FSM idle -> popped at edge t+1; O_TX falls after edge t+1; each bit exactly 16*BAUD_DIV cycles.
REQ-022 SHALL register O_TX (glitch-free).

Reset
REQ-023 RESET SHALL immediately force O_TX=1, O_TX_BUSY=0, O_TX_FULL=0, O_TX_EMPTY=1, pointers/counters 0, FSM IDLE; a frame in progress is abandoned, FIFO contents discarded.

Configuration
REQ-024 With UART_TX_PARITY_EN defined SHALL insert PARITY state between DATA and STOP, sending even parity of the DBIT data bits for 16 ticks; without it no parity bit, DATA -> STOP directly.

Structure
REQ-025 Package uart_pkg SHALL hold FSM state encoding and constant OVERSAMPLE=16.
REQ-026 FIFO SHALL be sub-module fifo_sync (parameterised width 8, depth 2^FIFO_W, push/pop/full/empty).

Verification (BAUD_DIV=2, bit = 32 cycles)
REQ-027 Write 0xA5 once, idle -> O_TX: 0,1,0,1,0,0,1,0,1,1 each 32 cycles (320 cycles), O_TX_BUSY high throughout, O_TX_EMPTY=1 after pop.
REQ-028 Hold I_WR_UART=1 20 cycles, data=cycle index 0..19 -> bytes 0..16 accepted, O_TX_FULL=1 after 17th write, 17..19 dropped; line emits 0..16 in order.
REQ-029 Push and pop same edge at occupancy 16 with I_WR_UART=1 -> write dropped, occupancy 15.
REQ-030 RESET mid DATA of 0x3C, FIFO holding 3 bytes -> O_TX=1 same cycle, O_TX_EMPTY=1, no further frames.
REQ-031 UART_TX_PARITY_EN defined, write 0xA5 -> 11-bit frame, parity bit 0; write 0x07 -> parity bit 1.
REQ-032 Back-to-back 0x00,0xFF -> second start bit begins immediately after first stop bit plus one cycle.
